// File: rtl/cnt_down_timer.sv
// Loadable prescaled down-counter: steps out_o toward zero once every DIV clocks while running.
// Optional macro CNT_AUTO_RELOAD_EN turns it into a periodic timer that reloads the last loaded value.
module cnt_down_timer #(
  parameter int DIV = 500,
  parameter int W   = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] din_i,
  input  logic         start_i,
  input  logic         pause_i,
  output logic [W-1:0] out_o,
  output logic         tick_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [W-1:0]  out_q, out_d;
  logic          tick_q, tick_d;
  logic          done_q, done_d;
  logic          busy_q;

`ifdef CNT_AUTO_RELOAD_EN
  logic [W-1:0]  reload_q, reload_d;
`endif

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    out_d   = out_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
`ifdef CNT_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          out_d = din_i;
          pre_d = '0;
`ifdef CNT_AUTO_RELOAD_EN
          reload_d = din_i;
`endif
        end else if (start_i) begin
          pre_d = '0;
          if (out_q != '0) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // pause wins over a coincident terminal count; pre stays frozen
        if (pause_i) begin
          state_d = ST_PAUSE;
        end else if (pre_q == PRE_LAST) begin
          pre_d  = '0;
          out_d  = out_q - W'(1);
          tick_d = 1'b1;
          if (out_q == W'(1)) begin
            done_d = 1'b1;
`ifdef CNT_AUTO_RELOAD_EN
            if (reload_q != '0) begin
              out_d = reload_q;
            end else begin
              state_d = ST_DONE;
            end
`else
            state_d = ST_DONE;
`endif
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      ST_PAUSE: begin
        if (load_i) begin
          out_d   = din_i;
          pre_d   = '0;
          state_d = ST_IDLE;
`ifdef CNT_AUTO_RELOAD_EN
          reload_d = din_i;
`endif
        end else if (start_i) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (load_i) begin
          out_d   = din_i;
          pre_d   = '0;
          state_d = ST_IDLE;
`ifdef CNT_AUTO_RELOAD_EN
          reload_d = din_i;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      out_q   <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef CNT_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      busy_q  <= (state_d == ST_RUN);
`ifdef CNT_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign out_o  = out_q;
  assign tick_o = tick_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
